// File: rtl/alu_ctrl_md_pkg.sv
// Shared codes for the ALU control / multiply-divide slice: ALU operation codes,
// main-decoder classes, R-type function codes and the multiply/divide FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_LUI = 4'b1000;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;
  localparam logic [2:0] OP_LUI   = 3'b110;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } md_state_t;

endpackage

// File: rtl/alu_ctrl_md_if.sv
// Execute-stage bundle between the pipeline (master) and the ALU control / MD unit (slave).
// Handshake: there is no ready; an instruction with valid=1 is consumed at the rising
// edge unless stall=1 in that cycle, in which case the master holds it unchanged.
interface alu_ctrl_md_if #(parameter int WIDTH = 32);
  logic             valid;
  logic [2:0]       alu_op;
  logic [5:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_func;
  logic             illegal;
  logic             md_busy;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] md_rdata;
  logic [1:0]       md_state;

  modport master (
    output valid, alu_op, func, a, b,
    input  alu_func, illegal, md_busy, stall, hi, lo, md_rdata, md_state
  );

  modport slave (
    input  valid, alu_op, func, a, b,
    output alu_func, illegal, md_busy, stall, hi, lo, md_rdata, md_state
  );
endinterface

// File: rtl/alu_ctrl_md_md_core.sv
// Multi-cycle multiply/divide engine: FSM, latency counter, operand capture and the
// HI/LO architectural registers (also written directly by mthi/mtlo).
module md_core
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             start_div,
  input  logic             start_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output md_state_t        state
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [4:0]         cnt;
  logic [WIDTH-1:0]   op_a, op_b;
  logic               op_div, op_signed;
  logic [WIDTH-1:0]   sa, sb;
  logic               s_div, s_signed;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [4:0]         lat;

  // A 1-cycle latency finishes on the start edge itself, so the result is then
  // computed from the live operands rather than the captured ones.
  always_comb begin
    sa       = (state == S_IDLE) ? a : op_a;
    sb       = (state == S_IDLE) ? b : op_b;
    s_div    = (state == S_IDLE) ? start_div : op_div;
    s_signed = (state == S_IDLE) ? start_signed : op_signed;
    lat      = start_div ? 5'(DIV_CYCLES) : 5'(MUL_CYCLES);
    prod     = '0;
    res_hi   = '0;
    res_lo   = '0;
    if (!s_div) begin
      if (s_signed)
        prod = $unsigned($signed({{WIDTH{sa[WIDTH-1]}}, sa}) *
                         $signed({{WIDTH{sb[WIDTH-1]}}, sb}));
      else
        prod = {{WIDTH{1'b0}}, sa} * {{WIDTH{1'b0}}, sb};
      {res_hi, res_lo} = prod;
    end else if (sb == '0) begin
      res_lo = '1;
      res_hi = sa;
    end else if (s_signed && sa == MIN_NEG && sb == '1) begin
      res_lo = MIN_NEG;
      res_hi = '0;
    end else if (s_signed) begin
      res_lo = $unsigned($signed(sa) / $signed(sb));
      res_hi = $unsigned($signed(sa) % $signed(sb));
    end else begin
      res_lo = sa / sb;
      res_hi = sa % sb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_div    <= 1'b0;
      op_signed <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_a      <= a;
            op_b      <= b;
            op_div    <= start_div;
            op_signed <= start_signed;
            cnt       <= lat - 5'd1;
            if (lat == 5'd1) begin
              hi <= res_hi;
              lo <= res_lo;
            end else begin
              state <= start_div ? S_DIV : S_MUL;
            end
          end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        default: begin
          // The edge that takes the counter to zero is the one that commits HI/LO.
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            hi    <= res_hi;
            lo    <= res_lo;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: rtl/alu_ctrl_md.sv
// ALU control decoder plus HI/LO multiply/divide unit with pipeline stall generation.
module alu_ctrl_md
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic           clk,
  input logic           reset,
  alu_ctrl_md_if.slave  bus
);

  logic      rtype, md_arith, md_move, start, wr_hi, wr_lo;
  md_state_t state;

  always_comb begin
    bus.alu_func = ALU_ADD;
    bus.illegal  = 1'b0;
    case (bus.alu_op)
      OP_ADD: bus.alu_func = ALU_ADD;
      OP_SUB: bus.alu_func = ALU_SUB;
      OP_OR:  bus.alu_func = ALU_OR;
      OP_AND: bus.alu_func = ALU_AND;
      OP_SLT: bus.alu_func = ALU_SLT;
      OP_LUI: bus.alu_func = ALU_LUI;
      OP_RTYPE: begin
        case (bus.func)
          F_ADD, F_ADDU, F_JR: bus.alu_func = ALU_ADD;
          F_SUB, F_SUBU:       bus.alu_func = ALU_SUB;
          F_AND:               bus.alu_func = ALU_AND;
          F_OR:                bus.alu_func = ALU_OR;
          F_SLT:               bus.alu_func = ALU_SLT;
          F_MULT, F_MULTU, F_DIV, F_DIVU,
          F_MFHI, F_MTHI, F_MFLO, F_MTLO: bus.alu_func = ALU_ADD;
          default:             bus.illegal  = bus.valid;
        endcase
      end
      default: bus.alu_func = ALU_ADD;
    endcase
  end

  assign rtype    = (bus.alu_op == OP_RTYPE);
  assign md_arith = rtype && (bus.func inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign md_move  = rtype && (bus.func inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO});

  // Only HI/LO users wait on the engine; everything else flows past it.
  assign bus.stall = bus.valid && (md_arith || md_move) && bus.md_busy;
  assign start     = bus.valid && md_arith && !bus.md_busy;
  assign wr_hi     = bus.valid && rtype && (bus.func == F_MTHI) && !bus.stall;
  assign wr_lo     = bus.valid && rtype && (bus.func == F_MTLO) && !bus.stall;

  always_comb begin
    bus.md_rdata = '0;
    if (bus.valid && rtype && !bus.stall) begin
      if (bus.func == F_MFHI)      bus.md_rdata = bus.hi;
      else if (bus.func == F_MFLO) bus.md_rdata = bus.lo;
    end
  end

  md_core #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_core (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_div    (bus.func[1]),
    .start_signed (!bus.func[0]),
    .a            (bus.a),
    .b            (bus.b),
    .wr_hi        (wr_hi),
    .wr_lo        (wr_lo),
    .wdata        (bus.a),
    .hi           (bus.hi),
    .lo           (bus.lo),
    .busy         (bus.md_busy),
    .state        (state)
  );

  assign bus.md_state = state;

endmodule

// File: doc/alu_ctrl_md.md
ALU_CTRL_MD -- requirements
Module: alu_ctrl_md

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of a, b, hi, lo.
REQ-002 SHALL have parameter MUL_CYCLES, default 5, mult/multu latency in cycles (legal range 1..31).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, div/divu latency in cycles (legal range 1..31).
REQ-004 Ports: clk  in  1  single clock, all state on rising edge.
REQ-005 Ports: reset  in  1  synchronous, active-high reset.
REQ-006 Ports: valid  in  1  the execute-stage instruction is real (not a bubble).
REQ-007 Ports: alu_op  in  3  main-decoder class (000 add, 001 sub, 010 R-type, 011 or, 100 and, 101 slt, 110 lui).
REQ-008 Ports: func  in  6  R-type function field.
REQ-009 Ports: a, b  in  WIDTH  rs/rt operand values.
REQ-010 Ports: alu_func  out  4  ALU operation code (combinational).
REQ-011 Ports: illegal  out  1  R-type func not recognised (combinational).
REQ-012 Ports: md_busy  out  1  multiply/divide in progress.
REQ-013 Ports: stall  out  1  hold the pipeline this cycle.
REQ-014 Ports: hi, lo  out  WIDTH  architectural HI/LO registers.
REQ-015 Ports: md_rdata  out  WIDTH  HI for mfhi, LO for mflo, else 0.

Function
REQ-016 alu_func SHALL map: add 0010, sub 0110, and 0000, or 0001, slt 0111, lui 1000.
REQ-017 alu_op 010 SHALL decode func: 100000/100001 add, 100010/100011 sub, 100100 and, 100101 or, 101010 slt, 001000 (jr) add.
REQ-018 Recognised R-type non-ALU funcs (mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011) SHALL yield alu_func add, illegal 0.
REQ-019 Any other R-type func SHALL yield alu_func add and illegal = valid; no latch inferred for any input.
REQ-020 MD start: valid, alu_op 010, func mult/multu/div/divu, md_busy 0, in cycle t; operands captured at t.
REQ-021 FSM states IDLE, MUL, DIV: IDLE->MUL or DIV on start; counter loads latency-1, decrements each cycle.
REQ-022 When counter reaches 0 in MUL/DIV, HI/LO SHALL update at that edge and FSM returns IDLE; new hi/lo visible at cycle t+LAT.
REQ-023 md_busy SHALL be 1 in cycles t+1 .. t+LAT-1 and 0 from t+LAT.
REQ-024 mult/multu: {hi,lo} = 2*WIDTH-bit signed/unsigned product of a, b.
REQ-025 div/divu: lo = quotient (truncate toward zero), hi = remainder (sign of dividend); signed/unsigned per func.
REQ-026 Divide by zero: lo = all ones, hi = dividend.
REQ-027 Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
REQ-028 stall SHALL = valid & alu_op 010 & func in {mult, multu, div, divu, mfhi, mflo, mthi, mtlo} & md_busy.
REQ-029 mthi/mtlo with valid, not stalled: hi (resp. lo) <= a at that edge.
REQ-030 mfhi/mflo: md_rdata = current hi/lo combinationally; 0 when stalled or not selected.
REQ-031 MD instructions presented while busy SHALL be ignored (no start, no write) and stalled; held instruction executes the cycle busy drops.
REQ-032 Non-MD instructions SHALL never stall, even while busy.

Reset
REQ-033 reset SHALL force FSM IDLE, counter 0, hi 0, lo 0, md_busy 0 at the next edge, regardless of state.
REQ-034 reset mid-operation SHALL abandon the operation; hi/lo read 0, no late write.
REQ-035 reset has priority over start and mthi/mtlo in the same cycle.

Structure
REQ-036 Shared package alu_pkg SHALL hold the alu_func codes, alu_op classes, func codes and FSM state enum.
REQ-037 One sub-module md_core (FSM, counter, operand registers, result computation) SHALL be instantiated; decode and stall stay in alu_ctrl_md.

Verification
REQ-038 alu_op 010, func 100011 -> alu_func 0110, illegal 0; func 111111, valid 1 -> illegal 1, alu_func 0010.
REQ-039 mult a=-3 b=7 at t -> md_busy 1 t+1..t+4, hi=FFFFFFFF lo=FFFFFFEB at t+5.
REQ-040 divu a=100 b=7 -> after 10 cycles lo=14 hi=2; div a=-7 b=2 -> lo=-3 hi=-1; div a=80000000 b=FFFFFFFF -> lo=80000000 hi=0.
REQ-041 div b=0 a=5 -> lo=FFFFFFFF hi=5; mflo during busy -> stall 1, md_rdata 0; add during busy -> stall 0.
REQ-042 mult started, reset at t+2 -> hi=lo=0, md_busy 0 at t+3, no update at t+5.
REQ-043 mthi a=1234 while idle -> hi=1234 next cycle; mfhi next -> md_rdata 1234.
